branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Parametrised, pipelined successor to the combinational branch resolver in the execute stage. It accepts one control-flow operation per cycle over a valid/ready handshake and computes target, link value, taken/mispredict status and the misalignment exception. It registers the result into a one-entry output stage, so latency is one cycle. Saturating branch and mispredict performance counters are included. Results feed PC-gen/BTB update, ID resolve, and the exception path.

Parameters:
XLEN, 64, address/data width
RVC, 1, 1 = compressed ISA supported (2-byte target alignment); 0 = 4-byte alignment required
CNT_WIDTH, 32, width of each performance counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  kill the held result; wins over the capture of a new result
valid_i  in  1  operation present
ready_o  out  1  stage can accept
is_branch_i  in  1  operation is a control-flow op (branch/JAL/JALR); 0 = other FU op
is_jalr_i  in  1  JALR: base is operand_a_i, target LSB forced 0
operand_a_i  in  XLEN  rs1 value
imm_i  in  XLEN  sign-extended offset
pc_i  in  XLEN  instruction PC
is_compressed_i  in  1  16-bit instruction
comp_res_i  in  1  taken (comparison result; 1 for jumps)
predict_valid_i  in  1  prediction present
predict_taken_i  in  1  predicted taken
predict_addr_i  in  XLEN  predicted target
res_valid_o  out  1  registered result valid
res_ready_i  in  1  consumer accepts result
res_pc_o  out  XLEN  BTB update PC
res_target_o  out  XLEN  resolved next fetch address
res_taken_o  out  1  taken
res_mispredict_o  out  1  mispredict
res_clear_o  out  1  clear BTB entry
link_o  out  XLEN  next_pc (rd write-back value)
exc_valid_o  out  1  instruction-address-misaligned exception
exc_tval_o  out  XLEN  faulting PC
cnt_clear_i  in  1  zero both counters
branch_cnt_o  out  CNT_WIDTH  retired control-flow results
mispredict_cnt_o  out  CNT_WIDTH  retired mispredicts

Behaviour:
- Reset: all res_*, link_o, exc_* = 0; counters = 0; ready_o = 1.
- ready_o = !res_valid_o || res_ready_i. Accept when valid_i && ready_o. The result appears the next cycle. The output register holds its value while res_valid_o && !res_ready_i.
- next_pc = pc_i + (is_compressed_i ? 2 : 4), modulo 2^XLEN.
- target = (is_jalr_i ? operand_a_i : pc_i) + imm_i, modulo 2^XLEN. For JALR, target bit 0 is cleared.
- misaligned = target[0] when RVC=1; target[1:0] != 0 when RVC=0.
- res_pc = pc_i if is_compressed_i || pc_i[1]==0; otherwise {pc_i[XLEN-1:2],2'b00} + 4.
- Accepted op with is_branch_i=1:
  - Result is always emitted.
  - target_o = comp_res_i ? target : next_pc; taken = comp_res_i.
  - If misaligned: exc_valid=1, tval=pc_i, mispredict=0.
  - Otherwise, mispredict = predict_valid ? ((predict_taken != comp_res) || (predict_taken && target != predict_addr)) : comp_res.
- Accepted op with is_branch_i=0 and predict_valid && predict_taken:
  - Emit mispredict=1, clear=1, target=next_pc, taken=0, exc=0.
- Accepted op with is_branch_i=0 and no taken prediction: no result is emitted (res_valid_o stays or goes 0 per the handshake).
- flush_i: res_valid_o <= 0 next cycle and the incoming op is discarded, including a same-cycle accept. Counters are not incremented for discarded ops.
- Counters update on the output handshake (res_valid_o && res_ready_i):
  - branch_cnt += 1 unless res_clear_o.
  - mispredict_cnt += 1 if res_mispredict_o.
  - Both saturate at all-ones.
  - cnt_clear_i has priority over a same-cycle increment.
- Reset asserted mid-operation: state returns to reset values immediately (asynchronous); the in-flight result is lost.

Test Plan:
- Basic taken branch: pc=0x1000, imm=0x20, comp=1, predict valid/taken addr 0x1020 -> next cycle res_valid=1, target=0x1020, taken=1, mispredict=0, link=0x1004; branch_cnt=1 after the handshake.
- JALR: operand_a=0x2003, imm=0, is_jalr=1, no prediction -> target=0x2002, mispredict=1, exc_valid=0 (RVC=1). With RVC=0, exc_valid=1, tval=pc.
- Wrong address: predict_taken addr 0x1040, actual 0x1020 -> mispredict=1, mispredict_cnt increments.
- Non-branch op predicted taken: is_branch=0, pc=0x3002, compressed=1 -> mispredict=1, clear=1, target=0x3004, branch_cnt unchanged.
- Back-pressure and flush: hold res_ready=0 for 3 cycles -> ready_o=0 and outputs stable. Then assert flush_i with valid_i -> res_valid=0 next cycle, counters unchanged.
- Saturation and clear: preload counters at all-ones (CNT_WIDTH=4) and retire a mispredict -> both stay 0xF. Assert cnt_clear_i together with a handshake -> both read 0.

Source files
------------

// File: rtl/branch_resolve_if.sv
// Request/result bundle for the branch resolve unit.
// The DUT takes the slave view; the producer/consumer side takes the master view.
interface branch_resolve_if #(
  parameter int XLEN      = 64,
  parameter int CNT_WIDTH = 32
);
  logic                 flush_i;
  logic                 valid_i;
  logic                 ready_o;
  logic                 is_branch_i;
  logic                 is_jalr_i;
  logic [XLEN-1:0]      operand_a_i;
  logic [XLEN-1:0]      imm_i;
  logic [XLEN-1:0]      pc_i;
  logic                 is_compressed_i;
  logic                 comp_res_i;
  logic                 predict_valid_i;
  logic                 predict_taken_i;
  logic [XLEN-1:0]      predict_addr_i;
  logic                 res_valid_o;
  logic                 res_ready_i;
  logic [XLEN-1:0]      res_pc_o;
  logic [XLEN-1:0]      res_target_o;
  logic                 res_taken_o;
  logic                 res_mispredict_o;
  logic                 res_clear_o;
  logic [XLEN-1:0]      link_o;
  logic                 exc_valid_o;
  logic [XLEN-1:0]      exc_tval_o;
  logic                 cnt_clear_i;
  logic [CNT_WIDTH-1:0] branch_cnt_o;
  logic [CNT_WIDTH-1:0] mispredict_cnt_o;

  modport master (
    output flush_i, valid_i, is_branch_i, is_jalr_i, operand_a_i, imm_i, pc_i,
           is_compressed_i, comp_res_i, predict_valid_i, predict_taken_i,
           predict_addr_i, res_ready_i, cnt_clear_i,
    input  ready_o, res_valid_o, res_pc_o, res_target_o, res_taken_o,
           res_mispredict_o, res_clear_o, link_o, exc_valid_o, exc_tval_o,
           branch_cnt_o, mispredict_cnt_o
  );

  modport slave (
    input  flush_i, valid_i, is_branch_i, is_jalr_i, operand_a_i, imm_i, pc_i,
           is_compressed_i, comp_res_i, predict_valid_i, predict_taken_i,
           predict_addr_i, res_ready_i, cnt_clear_i,
    output ready_o, res_valid_o, res_pc_o, res_target_o, res_taken_o,
           res_mispredict_o, res_clear_o, link_o, exc_valid_o, exc_tval_o,
           branch_cnt_o, mispredict_cnt_o
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Pipelined branch resolver: one op per cycle in, registered one-entry result
// stage out (latency 1), plus saturating branch / mispredict counters.
module branch_resolve_unit #(
  parameter int XLEN      = 64,
  parameter int RVC       = 1,
  parameter int CNT_WIDTH = 32
) (
  input logic              clk_i,
  input logic              rst_ni,
  branch_resolve_if.slave  bus
);

  logic [XLEN-1:0]      next_pc, target, res_pc_c, target_sel;
  logic                 misaligned, pred_taken_op, emit, mispredict_c;
  logic                 ready, accept, handshake;

  logic                 res_valid_q, taken_q, mispredict_q, clear_q, exc_q;
  logic [XLEN-1:0]      res_pc_q, target_q, link_q, tval_q;
  logic [CNT_WIDTH-1:0] branch_cnt_q, mispredict_cnt_q;

  // Resolve target, link value, alignment and prediction outcome of the incoming op.
  always_comb begin
    next_pc = bus.pc_i + (bus.is_compressed_i ? XLEN'(2) : XLEN'(4));
    target  = (bus.is_jalr_i ? bus.operand_a_i : bus.pc_i) + bus.imm_i;
    if (bus.is_jalr_i) target[0] = 1'b0;
    misaligned = (RVC != 0) ? target[0] : (target[1:0] != 2'b00);
    // A non-compressed op at a halfword offset spans into the next word; the BTB
    // is indexed by the word that holds its end.
    res_pc_c = (bus.is_compressed_i || !bus.pc_i[1]) ? bus.pc_i
             : {bus.pc_i[XLEN-1:2], 2'b00} + XLEN'(4);
    pred_taken_op = bus.predict_valid_i && bus.predict_taken_i;
    emit          = bus.is_branch_i || pred_taken_op;
    if (!bus.is_branch_i) mispredict_c = 1'b1;
    else if (misaligned) mispredict_c = 1'b0;
    else if (bus.predict_valid_i)
      mispredict_c = (bus.predict_taken_i != bus.comp_res_i) ||
                     (bus.predict_taken_i && (target != bus.predict_addr_i));
    else mispredict_c = bus.comp_res_i;
    target_sel = (bus.is_branch_i && bus.comp_res_i) ? target : next_pc;
  end

  assign ready     = !res_valid_q || bus.res_ready_i;
  assign accept    = bus.valid_i && ready;
  assign handshake = res_valid_q && bus.res_ready_i && !bus.flush_i;

  // One-entry result register; flush beats both capture and hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_valid_q  <= 1'b0;
      res_pc_q     <= '0;
      target_q     <= '0;
      link_q       <= '0;
      tval_q       <= '0;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      clear_q      <= 1'b0;
      exc_q        <= 1'b0;
    end else if (bus.flush_i) begin
      res_valid_q <= 1'b0;
    end else if (accept) begin
      res_valid_q <= emit;
      if (emit) begin
        res_pc_q     <= res_pc_c;
        target_q     <= target_sel;
        link_q       <= next_pc;
        taken_q      <= bus.is_branch_i && bus.comp_res_i;
        clear_q      <= !bus.is_branch_i;
        exc_q        <= bus.is_branch_i && misaligned;
        tval_q       <= bus.pc_i;
        mispredict_q <= mispredict_c;
      end
    end else if (bus.res_ready_i) begin
      res_valid_q <= 1'b0;
    end
  end

  // Saturating retire counters; a clear request overrides same-cycle increments.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (bus.cnt_clear_i) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (handshake) begin
      if (!clear_q && (branch_cnt_q != '1))
        branch_cnt_q <= branch_cnt_q + CNT_WIDTH'(1);
      if (mispredict_q && (mispredict_cnt_q != '1))
        mispredict_cnt_q <= mispredict_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign bus.ready_o          = ready;
  assign bus.res_valid_o      = res_valid_q;
  assign bus.res_pc_o         = res_pc_q;
  assign bus.res_target_o     = target_q;
  assign bus.res_taken_o      = taken_q;
  assign bus.res_mispredict_o = mispredict_q;
  assign bus.res_clear_o      = clear_q;
  assign bus.link_o           = link_q;
  // The exception flag is only meaningful alongside a live result.
  assign bus.exc_valid_o      = exc_q && res_valid_q;
  assign bus.exc_tval_o       = tval_q;
  assign bus.branch_cnt_o     = branch_cnt_q;
  assign bus.mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: an RVC=1 and an RVC=0 instance see identical
// stimulus and are both compared each cycle against a behavioural model.
module tb_branch_resolve_unit;

  localparam int XLEN = 64;
  localparam int CW   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_if #(.XLEN(XLEN), .CNT_WIDTH(CW)) bus0 ();
  branch_resolve_if #(.XLEN(XLEN), .CNT_WIDTH(CW)) bus1 ();

  branch_resolve_unit #(.XLEN(XLEN), .RVC(1), .CNT_WIDTH(CW)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus0.slave));
  branch_resolve_unit #(.XLEN(XLEN), .RVC(0), .CNT_WIDTH(CW)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus1.slave));

  assign bus1.flush_i         = bus0.flush_i;
  assign bus1.valid_i         = bus0.valid_i;
  assign bus1.is_branch_i     = bus0.is_branch_i;
  assign bus1.is_jalr_i       = bus0.is_jalr_i;
  assign bus1.operand_a_i     = bus0.operand_a_i;
  assign bus1.imm_i           = bus0.imm_i;
  assign bus1.pc_i            = bus0.pc_i;
  assign bus1.is_compressed_i = bus0.is_compressed_i;
  assign bus1.comp_res_i      = bus0.comp_res_i;
  assign bus1.predict_valid_i = bus0.predict_valid_i;
  assign bus1.predict_taken_i = bus0.predict_taken_i;
  assign bus1.predict_addr_i  = bus0.predict_addr_i;
  assign bus1.res_ready_i     = bus0.res_ready_i;
  assign bus1.cnt_clear_i     = bus0.cnt_clear_i;

  typedef struct {
    bit          v;
    logic [63:0] pc, target, link, tval;
    bit          taken, misp, clr, exc;
  } res_t;

  int   errors = 0;
  int   checks = 0;
  bit   mv [2];
  res_t mr [2];
  int   mb [2];
  int   mm [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected result of the op currently on the inputs, straight from the rules.
  function automatic res_t model_op(input bit rvc);
    res_t r;
    logic [63:0] np, tg;
    bit mis;
    np = bus0.pc_i + (bus0.is_compressed_i ? 64'd2 : 64'd4);
    tg = (bus0.is_jalr_i ? bus0.operand_a_i : bus0.pc_i) + bus0.imm_i;
    if (bus0.is_jalr_i) tg = tg & ~64'd1;
    mis = rvc ? (tg % 2 != 0) : (tg % 4 != 0);
    r = '{default: 0};
    r.link = np;
    r.pc = (bus0.is_compressed_i || (bus0.pc_i % 4) < 2) ? bus0.pc_i
         : (bus0.pc_i / 4) * 4 + 4;
    if (bus0.is_branch_i) begin
      r.v = 1;
      r.taken = bus0.comp_res_i;
      r.target = bus0.comp_res_i ? tg : np;
      if (mis) begin
        r.exc = 1;
        r.tval = bus0.pc_i;
      end else if (bus0.predict_valid_i)
        r.misp = (bus0.predict_taken_i != bus0.comp_res_i) ||
                 (bus0.predict_taken_i && tg != bus0.predict_addr_i);
      else
        r.misp = bus0.comp_res_i;
    end else if (bus0.predict_valid_i && bus0.predict_taken_i) begin
      r.v = 1;
      r.misp = 1;
      r.clr = 1;
      r.target = np;
    end
    return r;
  endfunction

  function automatic int sat(input int x);
    return (x >= 15) ? 15 : x + 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mv[i] = 0; mr[i] = '{default: 0}; mb[i] = 0; mm[i] = 0;
    end
  endtask

  task automatic cmp_unit(input int u, input logic rv, input logic rdy,
                          input logic [63:0] pc, input logic [63:0] tgt,
                          input logic [63:0] lnk, input logic [63:0] tval,
                          input logic tk, input logic mp, input logic cl,
                          input logic ex, input logic [3:0] bc, input logic [3:0] mc);
    chk($sformatf("u%0d.res_valid", u), 64'(rv), 64'(mv[u]));
    chk($sformatf("u%0d.ready", u), 64'(rdy), 64'(!mv[u] || bus0.res_ready_i));
    chk($sformatf("u%0d.exc_valid", u), 64'(ex), 64'(mv[u] && mr[u].exc));
    chk($sformatf("u%0d.branch_cnt", u), 64'(bc), 64'(mb[u]));
    chk($sformatf("u%0d.mispredict_cnt", u), 64'(mc), 64'(mm[u]));
    if (mv[u]) begin
      chk($sformatf("u%0d.res_pc", u), pc, mr[u].pc);
      chk($sformatf("u%0d.target", u), tgt, mr[u].target);
      chk($sformatf("u%0d.link", u), lnk, mr[u].link);
      chk($sformatf("u%0d.taken", u), 64'(tk), 64'(mr[u].taken));
      chk($sformatf("u%0d.mispredict", u), 64'(mp), 64'(mr[u].misp));
      chk($sformatf("u%0d.clear", u), 64'(cl), 64'(mr[u].clr));
      if (mr[u].exc) chk($sformatf("u%0d.tval", u), tval, mr[u].tval);
    end
  endtask

  task automatic check_all();
    cmp_unit(0, bus0.res_valid_o, bus0.ready_o, bus0.res_pc_o, bus0.res_target_o,
             bus0.link_o, bus0.exc_tval_o, bus0.res_taken_o, bus0.res_mispredict_o,
             bus0.res_clear_o, bus0.exc_valid_o, bus0.branch_cnt_o, bus0.mispredict_cnt_o);
    cmp_unit(1, bus1.res_valid_o, bus1.ready_o, bus1.res_pc_o, bus1.res_target_o,
             bus1.link_o, bus1.exc_tval_o, bus1.res_taken_o, bus1.res_mispredict_o,
             bus1.res_clear_o, bus1.exc_valid_o, bus1.branch_cnt_o, bus1.mispredict_cnt_o);
  endtask

  // Advance one clock: model the edge, then compare at the following negedge.
  task automatic tick();
    res_t nr [2];
    bit hs, acc;
    for (int i = 0; i < 2; i++) nr[i] = model_op(i == 0);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      hs  = mv[i] && bus0.res_ready_i && !bus0.flush_i;
      acc = bus0.valid_i && (!mv[i] || bus0.res_ready_i);
      if (bus0.cnt_clear_i) begin
        mb[i] = 0; mm[i] = 0;
      end else if (hs) begin
        if (!mr[i].clr) mb[i] = sat(mb[i]);
        if (mr[i].misp) mm[i] = sat(mm[i]);
      end
      if (bus0.flush_i) mv[i] = 0;
      else if (acc) begin
        mv[i] = nr[i].v;
        if (nr[i].v) mr[i] = nr[i];
      end else if (bus0.res_ready_i) mv[i] = 0;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    bus0.flush_i = 0; bus0.valid_i = 0; bus0.is_branch_i = 0; bus0.is_jalr_i = 0;
    bus0.operand_a_i = 0; bus0.imm_i = 0; bus0.pc_i = 0; bus0.is_compressed_i = 0;
    bus0.comp_res_i = 0; bus0.predict_valid_i = 0; bus0.predict_taken_i = 0;
    bus0.predict_addr_i = 0; bus0.res_ready_i = 1; bus0.cnt_clear_i = 0;
  endtask

  task automatic set_op(input bit br, input bit jalr, input logic [63:0] a,
                        input logic [63:0] imm, input logic [63:0] pc, input bit c,
                        input bit comp, input bit pv, input bit pt, input logic [63:0] pa);
    bus0.valid_i = 1; bus0.is_branch_i = br; bus0.is_jalr_i = jalr;
    bus0.operand_a_i = a; bus0.imm_i = imm; bus0.pc_i = pc; bus0.is_compressed_i = c;
    bus0.comp_res_i = comp; bus0.predict_valid_i = pv; bus0.predict_taken_i = pt;
    bus0.predict_addr_i = pa;
  endtask

  task automatic rand_op();
    logic [63:0] pc, imm;
    pc  = {$urandom(), $urandom()} & ~64'd1;
    imm = 64'($signed(12'($urandom())));
    set_op(1'($urandom_range(0, 3) != 0), 1'($urandom()), {$urandom(), $urandom()},
           imm, pc, 1'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()),
           ($urandom_range(0, 1) != 0) ? pc + imm : {$urandom(), $urandom()});
    bus0.valid_i     = ($urandom_range(0, 4) != 0);
    bus0.res_ready_i = ($urandom_range(0, 3) != 0);
    bus0.flush_i     = ($urandom_range(0, 15) == 0);
    bus0.cnt_clear_i = ($urandom_range(0, 31) == 0);
  endtask

  initial begin
    idle();
    model_reset();
    #12 rst_n = 1'b1;
    @(negedge clk);
    check_all();
    chk("reset.ready", 64'(bus0.ready_o), 64'd1);

    // Correctly predicted taken branch
    set_op(1, 0, 0, 64'h20, 64'h1000, 0, 1, 1, 1, 64'h1020);
    tick();
    chk("basic.target", bus0.res_target_o, 64'h1020);
    chk("basic.link", bus0.link_o, 64'h1004);
    chk("basic.mispredict", 64'(bus0.res_mispredict_o), 64'd0);
    idle();
    tick();
    chk("basic.branch_cnt", 64'(bus0.branch_cnt_o), 64'd1);

    // JALR to an odd address, no prediction
    set_op(1, 1, 64'h2003, 0, 64'h1100, 0, 1, 0, 0, 0);
    tick();
    chk("jalr.target", bus0.res_target_o, 64'h2002);
    chk("jalr.mispredict", 64'(bus0.res_mispredict_o), 64'd1);
    chk("jalr.exc_rvc1", 64'(bus0.exc_valid_o), 64'd0);
    chk("jalr.exc_rvc0", 64'(bus1.exc_valid_o), 64'd1);
    chk("jalr.tval_rvc0", bus1.exc_tval_o, 64'h1100);

    // Predicted taken to the wrong address
    set_op(1, 0, 0, 64'h20, 64'h1000, 0, 1, 1, 1, 64'h1040);
    tick();
    chk("wrongaddr.mispredict", 64'(bus0.res_mispredict_o), 64'd1);
    idle();
    tick();
    chk("wrongaddr.mispredict_cnt", 64'(bus0.mispredict_cnt_o), 64'd2);

    // Non-branch op predicted taken
    set_op(0, 0, 0, 0, 64'h3002, 1, 0, 1, 1, 64'h5000);
    tick();
    chk("nonbr.target", bus0.res_target_o, 64'h3004);
    chk("nonbr.clear", 64'(bus0.res_clear_o), 64'd1);
    idle();
    tick();
    chk("nonbr.branch_cnt", 64'(bus0.branch_cnt_o), 64'd3);

    // Back-pressure for three cycles, then flush with a new op
    set_op(1, 0, 0, 64'h40, 64'h4000, 0, 1, 1, 1, 64'h4040);
    tick();
    bus0.res_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp.ready", 64'(bus0.ready_o), 64'd0);
      chk("bp.target", bus0.res_target_o, 64'h4040);
    end
    bus0.flush_i = 1;
    tick();
    chk("flush.res_valid", 64'(bus0.res_valid_o), 64'd0);
    chk("flush.branch_cnt", 64'(bus0.branch_cnt_o), 64'd3);
    idle();
    tick();

    // Saturate both counters with unpredicted taken branches
    set_op(1, 0, 0, 64'h20, 64'h1000, 0, 1, 0, 0, 0);
    for (int i = 0; i < 18; i++) tick();
    idle();
    tick();
    chk("sat.branch_cnt", 64'(bus0.branch_cnt_o), 64'hF);
    chk("sat.mispredict_cnt", 64'(bus0.mispredict_cnt_o), 64'hF);
    set_op(1, 0, 0, 64'h20, 64'h1000, 0, 1, 0, 0, 0);
    tick();
    idle();
    bus0.cnt_clear_i = 1;
    tick();
    chk("clr.branch_cnt", 64'(bus0.branch_cnt_o), 64'd0);
    chk("clr.mispredict_cnt", 64'(bus0.mispredict_cnt_o), 64'd0);
    idle();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rand_op();
      tick();
    end

    // Asynchronous reset in the middle of an operation
    set_op(1, 0, 0, 64'h20, 64'h1000, 0, 1, 0, 0, 0);
    bus0.res_ready_i = 0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst.res_valid", 64'(bus0.res_valid_o), 64'd0);
    chk("arst.branch_cnt", 64'(bus1.branch_cnt_o), 64'd0);
    chk("arst.ready", 64'(bus0.ready_o), 64'd1);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
